pdm_mic_decimator: RTL and testbench

- Receive-side counterpart of the on-chip PDM audio encoder: converts a 1-bit PDM stream from an external PDM microphone into 16-bit PCM samples.
- Generates the microphone bit clock from the system clock and synchronises and samples the microphone data line.
- Filters the bit stream through a 3rd-order CIC decimator and emits one PCM sample with a single-cycle valid strobe per decimation period.
- Sits on the uio PMOD pins alongside the audio output; its samples feed the audio path or visualisation.

---
 rtl/pdm_mic_decimator_if.sv | 11 +
 rtl/pdm_mic_decimator.sv | 121 ++++++++++++
 tb/tb_pdm_mic_decimator.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/pdm_mic_decimator_if.sv
// PCM sample bus from the PDM microphone decimator: one sample word plus a
// single-cycle valid strobe.
interface pdm_mic_decimator_if #(
  parameter int W = 16
);
  logic [W-1:0] pcm_out;
  logic         pcm_valid;

  modport master (output pcm_out, output pcm_valid);
  modport slave  (input  pcm_out, input  pcm_valid);
endinterface

// File: rtl/pdm_mic_decimator.sv
// PDM microphone receiver: generates pdm_clk, samples the 1-bit stream at the
// end of each high phase and decimates it by 2^LOG2_DECIM through a 3rd-order CIC.
module pdm_mic_decimator #(
  parameter  int CLK_HALF   = 4,
  parameter  int LOG2_DECIM = 5,
  localparam int W          = 3 * LOG2_DECIM + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 pdm_data,
  output logic                 pdm_clk,
  pdm_mic_decimator_if.master  pcm
);

  localparam int                    DIV_W    = (CLK_HALF > 1) ? $clog2(CLK_HALF) : 1;
  localparam logic [DIV_W-1:0]      DIV_LAST = DIV_W'(CLK_HALF - 1);
  localparam logic [LOG2_DECIM-1:0] DEC_LAST = '1;

  logic                  pdm_meta, pdm_bit;
  logic [DIV_W-1:0]      div_cnt;
  logic                  strobe;
  logic [LOG2_DECIM-1:0] dec_cnt;
  logic [W-1:0]          int1_p0, int2_p0, int3_p0;
  logic [W-1:0]          int1_nxt, int2_nxt, int3_nxt;
  logic                  vld_p1;
  logic [W-1:0]          d1_p1, d2_p1, d3_p1;
  logic [W-1:0]          c1, c2, c3;

  // Two-flop synchroniser for the asynchronous microphone data line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pdm_meta <= 1'b0;
      pdm_bit  <= 1'b0;
    end else begin
      pdm_meta <= pdm_data;
      pdm_bit  <= pdm_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      pdm_clk <= 1'b0;
    end else if (!en) begin
      div_cnt <= '0;
      pdm_clk <= 1'b0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
      pdm_clk <= ~pdm_clk;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Integrators chain through the freshly updated value of the previous stage;
  // modulo-2^W wrap is what makes the later comb differences come out right.
  always_comb begin
    strobe   = en && (div_cnt == DIV_LAST) && pdm_clk;
    int1_nxt = int1_p0 + {{(W-1){1'b0}}, pdm_bit};
    int2_nxt = int2_p0 + int1_nxt;
    int3_nxt = int3_p0 + int2_nxt;
    c1       = int3_p0 - d1_p1;
    c2       = c1 - d2_p1;
    c3       = c2 - d3_p1;
  end

  // ---- stage p0: integrate on each strobe, flag the decimation strobe ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int1_p0 <= '0;
      int2_p0 <= '0;
      int3_p0 <= '0;
      dec_cnt <= '0;
      vld_p1  <= 1'b0;
    end else if (!en) begin
      int1_p0 <= '0;
      int2_p0 <= '0;
      int3_p0 <= '0;
      dec_cnt <= '0;
      vld_p1  <= 1'b0;
    end else begin
      vld_p1 <= strobe && (dec_cnt == DEC_LAST);
      if (strobe) begin
        int1_p0 <= int1_nxt;
        int2_p0 <= int2_nxt;
        int3_p0 <= int3_nxt;
        dec_cnt <= dec_cnt + LOG2_DECIM'(1);
      end
    end
  end

  // ---- stage p1: comb section at the decimated rate ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d1_p1 <= '0;
      d2_p1 <= '0;
      d3_p1 <= '0;
    end else if (!en) begin
      d1_p1 <= '0;
      d2_p1 <= '0;
      d3_p1 <= '0;
    end else if (vld_p1) begin
      d1_p1 <= int3_p0;
      d2_p1 <= c1;
      d3_p1 <= c2;
    end
  end

  // ---- stage p2: registered PCM output; en low drops a pending comb step ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcm.pcm_out   <= '0;
      pcm.pcm_valid <= 1'b0;
    end else begin
      pcm.pcm_valid <= en && vld_p1;
      if (en && vld_p1) pcm.pcm_out <= c3;
    end
  end

endmodule

// File: tb/tb_pdm_mic_decimator.sv
// Scoreboard bench for pdm_mic_decimator: stimulus queues expected samples with
// their arrival cycle; monitors pop and compare on every pcm_valid.
module tb_pdm_mic_decimator;

  logic clk = 1'b0;
  logic rst_n, en, en2, pdm_data;
  logic pdm_clk, pdm_clk2;

  pdm_mic_decimator_if #(.W(16)) pcm_a ();
  pdm_mic_decimator_if #(.W(7))  pcm_b ();

  pdm_mic_decimator dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .pdm_data (pdm_data),
    .pdm_clk  (pdm_clk),
    .pcm      (pcm_a)
  );

  pdm_mic_decimator #(.CLK_HALF(1), .LOG2_DECIM(2)) dut_small (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en2),
    .pdm_data (pdm_data),
    .pdm_clk  (pdm_clk2),
    .pcm      (pcm_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int val;
    int cyc;
    bit care;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t ea, eb;
  bit   alt_on = 1'b0;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Default DUT: first sample 2*4*32+1 cycles after the enabling negedge, then every 256
  task automatic push_a(input int c, input int idx, input int val, input bit care);
    q_a.push_back('{val: val, cyc: c + 257 + 256 * idx, care: care});
  endtask

  // Small DUT (CLK_HALF=1, R=4): first sample 9 cycles after enable, then every 8
  task automatic push_b(input int c, input int idx, input int val);
    q_b.push_back('{val: val, cyc: c + 9 + 8 * idx, care: 1'b1});
  endtask

  task automatic drain_a(input int limit);
    int n = 0;
    while (q_a.size() != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("drain_a_pending", q_a.size(), 0);
    q_a.delete();
  endtask

  task automatic drain_b(input int limit);
    int n = 0;
    while (q_b.size() != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("drain_b_pending", q_b.size(), 0);
    q_b.delete();
  endtask

  always @(negedge clk) begin
    if (pcm_a.pcm_valid) begin
      if (q_a.size() == 0) check("unexpected_valid_a", cyc, -1);
      else begin
        ea = q_a.pop_front();
        check("valid_cycle_a", cyc, ea.cyc);
        if (ea.care) check("pcm_out_a", int'(pcm_a.pcm_out), ea.val);
      end
    end
  end

  always @(negedge clk) begin
    if (pcm_b.pcm_valid) begin
      if (q_b.size() == 0) check("unexpected_valid_b", cyc, -1);
      else begin
        eb = q_b.pop_front();
        check("valid_cycle_b", cyc, eb.cyc);
        check("pcm_out_b", int'(pcm_b.pcm_out), eb.val);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int k;
    int prev;
    int bad;
    int t_rise[2];

    rst_n = 1'b0; en = 1'b0; en2 = 1'b0; pdm_data = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_pcm_out", int'(pcm_a.pcm_out), 0);
    check("reset_pcm_valid", int'(pcm_a.pcm_valid), 0);
    check("reset_pdm_clk", int'(pdm_clk), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Constant 0: pdm_clk period 8, all samples zero
    c = cyc; en = 1'b1;
    for (int i = 0; i < 4; i++) push_a(c, i, 0, 1'b1);
    k = 0; prev = 0;
    for (int n = 0; n < 40 && k < 2; n++) begin
      @(negedge clk);
      if (pdm_clk && prev == 0) begin
        t_rise[k] = cyc;
        k++;
      end
      prev = int'(pdm_clk);
    end
    check("pdm_clk_rises_seen", k, 2);
    if (k == 2) begin
      check("pdm_clk_first_rise", t_rise[0], c + 4);
      check("pdm_clk_period", t_rise[1] - t_rise[0], 8);
    end
    drain_a(1300);
    en = 1'b0;
    repeat (4) @(negedge clk);

    // Constant 1: transient 5984, 27808, then R^3 = 32768
    pdm_data = 1'b1;
    repeat (4) @(negedge clk);
    c = cyc; en = 1'b1;
    push_a(c, 0, 5984, 1'b1);
    push_a(c, 1, 27808, 1'b1);
    push_a(c, 2, 32768, 1'b1);
    push_a(c, 3, 32768, 1'b1);
    push_a(c, 4, 32768, 1'b1);
    drain_a(1600);

    // en low for 100 clk mid-period: pdm_clk low, no valid, output held
    repeat (100) @(negedge clk);
    en = 1'b0;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (pdm_clk) bad++;
    end
    check("en_low_pdm_clk_high_cycles", bad, 0);
    check("en_low_pcm_out_held", int'(pcm_a.pcm_out), 32768);
    c = cyc; en = 1'b1;
    push_a(c, 0, 5984, 1'b1);
    push_a(c, 1, 27808, 1'b1);
    push_a(c, 2, 32768, 1'b1);
    drain_a(1100);

    // Asynchronous reset between clock edges
    repeat (50) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_pcm_out", int'(pcm_a.pcm_out), 0);
    check("async_rst_pcm_valid", int'(pcm_a.pcm_valid), 0);
    check("async_rst_pdm_clk", int'(pdm_clk), 0);
    @(negedge clk);
    c = cyc; rst_n = 1'b1;
    push_a(c, 0, 5984, 1'b1);
    push_a(c, 1, 27808, 1'b1);
    drain_a(600);
    en = 1'b0;
    repeat (4) @(negedge clk);

    // Alternating bits: toggle data after each pdm_clk falling edge
    pdm_data = 1'b0;
    repeat (4) @(negedge clk);
    alt_on = 1'b1;
    fork
      while (alt_on) begin
        @(negedge pdm_clk);
        @(negedge clk);
        if (alt_on) pdm_data = ~pdm_data;
      end
    join_none
    c = cyc; en = 1'b1;
    for (int i = 0; i < 3; i++) push_a(c, i, 0, 1'b0);
    push_a(c, 3, 16384, 1'b1);
    push_a(c, 4, 16384, 1'b1);
    drain_a(1600);
    alt_on = 1'b0;
    en = 1'b0;
    repeat (20) @(negedge clk);

    // CLK_HALF=1, R=4, constant 1: 20, 60, then 64 every 8 clk
    pdm_data = 1'b1;
    repeat (4) @(negedge clk);
    c = cyc; en2 = 1'b1;
    push_b(c, 0, 20);
    push_b(c, 1, 60);
    push_b(c, 2, 64);
    push_b(c, 3, 64);
    push_b(c, 4, 64);
    drain_b(100);
    en2 = 1'b0;
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
